// File: rtl/snake_collision_scanner_if.sv
// snake_collision_scanner_if: request/result bundle between the movement logic and the collision scanner.
interface snake_collision_scanner_if #(
    parameter int MAX_LEN  = 64,
    parameter int POS_BITS = 13,
    parameter int FOOD_CNT = 2,
    parameter int FIDX_W   = (FOOD_CNT > 1) ? $clog2(FOOD_CNT) : 1
);
    logic                         start;
    logic [POS_BITS-1:0]          snake_head;
    logic [POS_BITS*MAX_LEN-1:0]  snake_body_flat;
    logic [6:0]                   snake_length;
    logic [1:0]                   direction_in;
    logic [POS_BITS*FOOD_CNT-1:0] food_flat;
    logic [FOOD_CNT-1:0]          food_valid;
    logic                         busy;
    logic                         done;
    logic                         self_hit;
    logic                         wall_hit;
    logic                         collision;
    logic                         food_hit;
    logic [FIDX_W-1:0]            food_idx;

    modport master (
        output start, snake_head, snake_body_flat, snake_length, direction_in, food_flat, food_valid,
        input  busy, done, self_hit, wall_hit, collision, food_hit, food_idx
    );
    modport slave (
        input  start, snake_head, snake_body_flat, snake_length, direction_in, food_flat, food_valid,
        output busy, done, self_hit, wall_hit, collision, food_hit, food_idx
    );
endinterface

// File: rtl/snake_collision_scanner.sv
// snake_collision_scanner: multi-cycle head-vs-body scan with early exit, plus wall and food checks.
// Define SNAKE_COLLISION_WRAP_EN for a toroidal board (wall detection removed).
module snake_collision_scanner #(
    parameter int MAX_LEN  = 64,
    parameter int POS_BITS = 13,
    parameter int GRID_W   = 100,
    parameter int GRID_H   = 75,
    parameter int LANES    = 4,
    parameter int FOOD_CNT = 2
) (
    input logic clk,
    input logic rst_n,
    snake_collision_scanner_if.slave bus
);
    localparam int FIDX_W = (FOOD_CNT > 1) ? $clog2(FOOD_CNT) : 1;
    // wide enough for idx + LANES with the 7-bit length input
    localparam int IW = $clog2(MAX_LEN + LANES + 128);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]          state;
    logic [POS_BITS-1:0] head_q;
    logic [IW-1:0]       len_q;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       len_in;
    logic [LANES-1:0]    lane_hit;
    logic                wall_nxt;
    logic                food_nxt;
    logic [FIDX_W-1:0]   fidx_nxt;
    logic                self_q;
    logic                wall_q;
    logic                food_q;
    logic                done_q;
    logic [FIDX_W-1:0]   fidx_q;

    assign len_in = (IW'(bus.snake_length) > IW'(MAX_LEN)) ? IW'(MAX_LEN) : IW'(bus.snake_length);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [IW-1:0] seg;
        assign seg = idx + IW'(g);
        assign lane_hit[g] = (seg < len_q) && (bus.snake_body_flat[seg*POS_BITS +: POS_BITS] == head_q);
    end

`ifdef SNAKE_COLLISION_WRAP_EN
    assign wall_nxt = 1'b0;
`else
    logic [POS_BITS-1:0] x;
    logic [POS_BITS-1:0] y;
    assign x = bus.snake_head % POS_BITS'(GRID_W);
    assign y = bus.snake_head / POS_BITS'(GRID_W);
    assign wall_nxt = (bus.direction_in == 2'b00) ? (y == '0) :
                      (bus.direction_in == 2'b01) ? (x == POS_BITS'(GRID_W - 1)) :
                      (bus.direction_in == 2'b10) ? (y == POS_BITS'(GRID_H - 1)) : (x == '0);
`endif

    always_comb begin
        food_nxt = 1'b0;
        fidx_nxt = '0;
        for (int i = FOOD_CNT - 1; i >= 0; i--)
            if (bus.food_valid[i] && bus.food_flat[i*POS_BITS +: POS_BITS] == bus.snake_head) begin
                food_nxt = 1'b1;
                fidx_nxt = FIDX_W'(i);
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            head_q <= '0;
            len_q  <= '0;
            idx    <= '0;
            self_q <= 1'b0;
            wall_q <= 1'b0;
            food_q <= 1'b0;
            fidx_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    state  <= SCAN;
                    head_q <= bus.snake_head;
                    len_q  <= len_in;
                    idx    <= IW'(1);
                    self_q <= 1'b0;
                    wall_q <= wall_nxt;
                    food_q <= food_nxt;
                    fidx_q <= fidx_nxt;
                end
            end else if (|lane_hit || (idx + IW'(LANES) >= len_q)) begin
                state  <= IDLE;
                done_q <= 1'b1;
                self_q <= |lane_hit;
            end else begin
                idx <= idx + IW'(LANES);
            end
        end

    assign bus.busy      = (state == SCAN);
    assign bus.done      = done_q;
    assign bus.self_hit  = self_q;
    assign bus.wall_hit  = wall_q;
    assign bus.collision = self_q | wall_q;
    assign bus.food_hit  = food_q;
    assign bus.food_idx  = fidx_q;
endmodule

// File: tb/tb_snake_collision_scanner.sv
// tb_snake_collision_scanner: directed and randomized checks against a behavioural model of the scanner.
module tb_snake_collision_scanner;
    localparam int ML = 64;
    localparam int PB = 13;
    localparam int GW = 100;
    localparam int GH = 75;
    localparam int LANES = 4;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [PB-1:0] body[ML];
    logic [PB-1:0] fd[FC];
    int e_self, e_wall, e_food, e_fidx, e_cyc;

    snake_collision_scanner_if bus ();
    snake_collision_scanner #(.MAX_LEN(ML), .POS_BITS(PB), .GRID_W(GW), .GRID_H(GH),
                              .LANES(LANES), .FOOD_CNT(FC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < ML; i++) bus.snake_body_flat[i*PB +: PB] = body[i];
        for (int i = 0; i < FC; i++) bus.food_flat[i*PB +: PB] = fd[i];
    endtask

    task automatic fill_body(input logic [PB-1:0] head);
        for (int i = 0; i < ML; i++)
            do body[i] = PB'($urandom_range(0, GW*GH-1)); while (body[i] == head);
        body[0] = head;
    endtask

    task automatic model();
        int len, j, x, y;
        len = (bus.snake_length > 7'd64) ? 64 : int'(bus.snake_length);
        j = 0;
        for (int i = len - 1; i >= 1; i--) if (body[i] == bus.snake_head) j = i;
        e_self = (j != 0);
        e_cyc = (j != 0) ? (j - 1) / LANES + 1 : (len <= 1 ? 1 : (len - 1 + LANES - 1) / LANES);
        x = int'(bus.snake_head) % GW;
        y = int'(bus.snake_head) / GW;
`ifdef SNAKE_COLLISION_WRAP_EN
        e_wall = 0;
`else
        case (bus.direction_in)
            2'b00: e_wall = (y == 0);
            2'b01: e_wall = (x == GW - 1);
            2'b10: e_wall = (y == GH - 1);
            default: e_wall = (x == 0);
        endcase
`endif
        e_food = 0;
        e_fidx = 0;
        for (int i = FC - 1; i >= 0; i--)
            if (bus.food_valid[i] && fd[i] == bus.snake_head) begin
                e_food = 1;
                e_fidx = i;
            end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_self"}, bus.self_hit, 0);
        chk({tag, "_wall"}, bus.wall_hit, 0);
        chk({tag, "_coll"}, bus.collision, 0);
        chk({tag, "_food"}, bus.food_hit, 0);
        chk({tag, "_fidx"}, bus.food_idx, 0);
    endtask

    task automatic run_scan(input string tag);
        int n;
        pack();
        model();
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.snake_head = PB'($urandom_range(0, GW*GH-1));
        bus.snake_length = 7'($urandom);
        bus.direction_in = 2'($urandom);
        bus.food_valid = FC'($urandom);
        chk({tag, "_busy"}, bus.busy, 1);
        n = 0;
        while (!bus.done && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_cycles"}, n, e_cyc);
        chk({tag, "_busy_done"}, bus.busy, 0);
        chk({tag, "_self"}, bus.self_hit, e_self);
        chk({tag, "_wall"}, bus.wall_hit, e_wall);
        chk({tag, "_coll"}, bus.collision, (e_self | e_wall) != 0);
        chk({tag, "_food"}, bus.food_hit, e_food);
        chk({tag, "_fidx"}, bus.food_idx, e_fidx);
        @(posedge clk);
        #1 chk({tag, "_pulse"}, bus.done, 0);
    endtask

    initial begin
        int dones[$];
        int n;
        logic [PB-1:0] h;
        bus.start = 1'b0;
        bus.snake_head = '0;
        bus.snake_body_flat = '0;
        bus.snake_length = '0;
        bus.direction_in = '0;
        bus.food_flat = '0;
        bus.food_valid = '0;
        fd[0] = '0;
        fd[1] = '0;
        #12 check_idle_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // no hit, L=9: two scan cycles
        bus.snake_head = 505; fill_body(505); bus.snake_length = 9; bus.direction_in = 2'b01;
        run_scan("nohit");
        // head on segment 2: early exit after first cycle
        bus.snake_head = 505; fill_body(505); body[2] = 505; bus.snake_length = 9; bus.direction_in = 2'b01;
        run_scan("self2");
        // right edge moving right, L=1
        bus.snake_head = 99; fill_body(99); bus.snake_length = 1; bus.direction_in = 2'b01;
        run_scan("wall");
        // food slot priority and enable
        bus.snake_head = 300; fill_body(300); bus.snake_length = 5; bus.direction_in = 2'b10;
        fd[0] = 300; fd[1] = 300; bus.food_valid = 2'b10;
        run_scan("food1");
        bus.snake_head = 300; bus.snake_length = 5; bus.direction_in = 2'b10; bus.food_valid = 2'b00;
        run_scan("food0");
        bus.snake_head = 300; bus.snake_length = 5; bus.direction_in = 2'b10; bus.food_valid = 2'b11;
        run_scan("food_lo");

        // start held high, length clamped to 64: one request per S+1 cycles
        bus.snake_head = 1234; fill_body(1234); bus.snake_length = 100; bus.direction_in = 2'b00;
        bus.food_valid = 2'b00; pack(); model();
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3 * (e_cyc + 1); c++) begin
            @(posedge clk);
            #1 if (bus.done) dones.push_back(c);
        end
        bus.start = 1'b0;
        chk("cont_count", dones.size(), 3);
        for (int i = 0; i < 3 && i < dones.size(); i++)
            chk($sformatf("cont_done%0d", i), dones[i], e_cyc + i * (e_cyc + 1));
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("cont_drain", bus.done, 1);

        // reset in scan cycle 3 aborts everything
        bus.snake_head = 99; fill_body(99); bus.snake_length = 64; bus.direction_in = 2'b01;
        fd[0] = 99; bus.food_valid = 2'b01; pack();
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("abort_wall_pre", bus.wall_hit, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("abort");
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(posedge clk);
            #1 n += bus.done;
        end
        chk("abort_no_done", n, 0);
        bus.snake_head = 99; bus.snake_length = 64; bus.direction_in = 2'b01; bus.food_valid = 2'b01;
        run_scan("after_abort");

        // randomized requests
        for (int t = 0; t < 40; t++) begin
            h = PB'($urandom_range(0, GW*GH-1));
            case ($urandom_range(0, 5))
                0: h = PB'($urandom_range(0, GW-1));
                1: h = PB'((GH-1)*GW + $urandom_range(0, GW-1));
                2: h = PB'($urandom_range(0, GH-1) * GW);
                3: h = PB'($urandom_range(0, GH-1) * GW + GW - 1);
                default: ;
            endcase
            bus.snake_head = h;
            fill_body(h);
            if ($urandom_range(0, 1)) body[$urandom_range(1, ML-1)] = h;
            bus.snake_length = 7'($urandom_range(0, 100));
            bus.direction_in = 2'($urandom);
            for (int i = 0; i < FC; i++) fd[i] = $urandom_range(0, 1) ? h : PB'($urandom_range(0, GW*GH-1));
            bus.food_valid = FC'($urandom);
            run_scan($sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
